aquatux_spi_slave: RTL

- SPI responder (slave) that answers an SPI master's SCLK/SS/MOSI and drives MISO.
- Used as a bench/board stand-in for the AD7264-style converter, and as the slave port for inter-board links on AquaTux.
- Fully synchronous to the system clock: SCLK, SS and MOSI are oversampled, never used as clocks.
- Parallel side: a single-word transmit buffer and a received-word strobe.

---
 rtl/aquatux_spi_pkg.sv | 30 +++
 rtl/spi_edge_sync.sv | 33 +++
 rtl/aquatux_spi_slave.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/aquatux_spi_pkg.sv
// Shared definitions for the AquaTux SPI responder.
// Holds the FSM state encoding, the default frame width and the
// CPOL/CPHA -> sample/shift edge decode used by the top level.
package aquatux_spi_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // FSM state encoding (kept as plain constants for legacy tools)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Which synchronised SCLK edge is the sample edge and which is the shift edge.
  typedef struct packed {
    logic sample_on_rise;
    logic shift_on_rise;
  } edge_sel_t;

  // Leading edge is the move away from CPOL. Sampling on leading (CPHA=0)
  // is a rising edge when CPOL=0; sampling on trailing (CPHA=1) is a rising
  // edge when CPOL=1. Hence sample-on-rise = ~(CPOL ^ CPHA).
  function automatic edge_sel_t edge_select(input logic cpol, input logic cpha);
    edge_sel_t s;
    s.sample_on_rise = ~(cpol ^ cpha);
    s.shift_on_rise  = cpol ^ cpha;
    return s;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Synchroniser for one asynchronous SPI pin plus rise/fall pulse outputs.
// Ports: i_clk system clock, i_rst_n async active-low reset, i_d raw pin,
//        o_rise / o_fall one-cycle pulses on the synchronised level.
// An edge on i_d shows up on o_rise/o_fall SYNC_STAGES cycles later, so the
// consuming logic acts on it SYNC_STAGES+1 cycles after the pin moved.
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule

// File: rtl/aquatux_spi_slave.sv
// SPI responder, fully oversampled on Clk (SCLK/SS/MOSI are never clocks).
// Ports: Clk/resetn; CPOL/CPHA mode select; SCLK/SS/MOSI from master; MISO and
//        MISO_OE to master; tx_data/tx_load/tx_ready single-word transmit
//        buffer; rx_data/rx_valid received word; frame_err and tx_underrun pulses.
// Build option: define AQUATUX_SPI_SLAVE_ECHO_EN to send the last received
// word (instead of zeros) on a frame that starts with an empty buffer.
module aquatux_spi_slave
  import aquatux_spi_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             resetn,
  input  logic             CPOL,
  input  logic             CPHA,
  input  logic             SCLK,
  input  logic             SS,
  input  logic             MOSI,
  output logic             MISO,
  output logic             MISO_OE,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             tx_underrun
);

  localparam int             CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

  logic             w_sclk_rise, w_sclk_fall;
  logic             w_ss_rise, w_ss_fall;
  logic             w_mosi;
  logic             w_sample, w_shift_edge;
  edge_sel_t        w_edge;
  logic [WIDTH-1:0] w_underrun_word;
  logic [WIDTH-1:0] w_frame_word;

  logic [SYNC_STAGES-1:0] r_mosi_sync;

  state_t           r_state;
  logic [WIDTH-1:0] r_buf;
  logic             r_buf_full;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_bitcnt;
  logic             r_miso;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_frame_err;
  logic             r_tx_underrun;

  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
    .i_clk   (Clk),
    .i_rst_n (resetn),
    .i_d     (SCLK),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  // SS chain resets to "low": if SS is already low when reset releases no
  // fall is seen, so a frame cut by reset is ignored until SS goes high and
  // falls again. A rise seen after reset only lands in IDLE, where it is ignored.
  spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_ss_sync (
    .i_clk   (Clk),
    .i_rst_n (resetn),
    .i_d     (SS),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  // MOSI needs the same depth as SCLK so the sampled bit lines up with the
  // detected sample edge; no edge outputs are needed.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
    end
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_edge       = edge_select(CPOL, CPHA);
  assign w_sample     = w_edge.sample_on_rise ? w_sclk_rise : w_sclk_fall;
  assign w_shift_edge = w_edge.shift_on_rise  ? w_sclk_rise : w_sclk_fall;

`ifdef AQUATUX_SPI_SLAVE_ECHO_EN
  assign w_underrun_word = r_rx_data;
`else
  assign w_underrun_word = '0;
`endif

  assign w_frame_word = r_buf_full ? r_buf : w_underrun_word;

  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_buf         <= '0;
      r_buf_full    <= 1'b0;
      r_shift       <= '0;
      r_bitcnt      <= '0;
      r_miso        <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_tx_underrun <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_tx_underrun <= 1'b0;

      // A load is only taken into an empty buffer; a full buffer keeps its word.
      // On the SS-fall cycle the buffer is still seen as full if it holds the
      // word for this frame, so a load then only lands when it was empty.
      if (tx_load && !r_buf_full) begin
        r_buf      <= tx_data;
        r_buf_full <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_miso <= 1'b0;
          if (w_ss_fall) begin
            r_shift       <= w_frame_word;
            r_tx_underrun <= ~r_buf_full;
            if (r_buf_full) begin
              r_buf_full <= 1'b0;
            end
            r_bitcnt <= '0;
            // CPHA=0 must have the MSB on the wire before the first sample edge;
            // CPHA=1 drives it on the first leading (shift) edge instead.
            r_miso  <= CPHA ? 1'b0 : w_frame_word[WIDTH-1];
            r_state <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (w_ss_rise) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else if (w_sample) begin
            r_shift  <= {r_shift[WIDTH-2:0], w_mosi};
            r_bitcnt <= r_bitcnt + CW'(1);
            if (r_bitcnt == LAST_BIT) begin
              r_rx_data  <= {r_shift[WIDTH-2:0], w_mosi};
              r_rx_valid <= 1'b1;
              r_state    <= ST_DONE;
            end
          end else if (w_shift_edge) begin
            // After a sample the MSB of the shift register is already the next
            // transmit bit; before the first sample (CPHA=1) it is the first bit.
            r_miso <= r_shift[WIDTH-1];
          end
        end

        ST_DONE: begin
          if (w_ss_rise) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign MISO        = r_miso;
  assign MISO_OE     = (r_state != ST_IDLE);
  assign tx_ready    = ~r_buf_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign tx_underrun = r_tx_underrun;

endmodule
